// File: rtl/wave_key_ctrl.sv
// wave_key_ctrl
// Turns debounced key events into waveform-generator settings for the HDMI
// wave display. UP (key0) and DOWN (key1) adjust the field picked by MODE
// (key2). UP/DOWN give one step on press, another after a long hold, then
// auto-repeat. HOLD (key3) toggles display freeze.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high
//   key_flag    one-cycle event pulse per key (bit i = key i)
//   key_state   debounced level per key, 0 = pressed, 1 = released
//   wave_sel    0 sine, 1 square, 2 triangle, 3 sawtooth
//   amp_idx     amplitude index, 0..7
//   freq_idx    frequency index, 0..FREQ_MAX
//   field_sel   field adjusted by UP/DOWN: 0 wave, 1 amp, 2 freq
//   hold        display freeze
//   cfg_update  one-cycle pulse in the first cycle a changed value is visible
//
// UP/DOWN key FSM:
//   state   | meaning
//   IDLE    | key released, no timing in progress
//   PRESSED | first step given, counting toward the long-press step
//   REPEAT  | long-press step given, counting toward the next repeat step

module wave_key_ctrl #(
    parameter int LONG_CYC   = 25_000_000,
    parameter int REPEAT_CYC = 5_000_000,
    parameter int CNT_W      = 25,
    parameter int AMP_RST    = 4,
    parameter int FREQ_MAX   = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_flag,
    input  logic [3:0] key_state,
    output logic [1:0] wave_sel,
    output logic [2:0] amp_idx,
    output logic [3:0] freq_idx,
    output logic [1:0] field_sel,
    output logic       hold,
    output logic       cfg_update
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } key_st_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
    localparam logic [2:0]       AMP_RST_V   = 3'(AMP_RST);
    localparam logic [3:0]       FREQ_MAX_V  = 4'(FREQ_MAX);

    logic [3:0]       press;
    logic [1:0]       rel;
    logic [1:0]       step;
    key_st_t          key_st  [2];
    logic [CNT_W-1:0] key_cnt [2];

    logic             up;
    logic             dn;
    logic [1:0]       wave_nxt;
    logic [2:0]       amp_nxt;
    logic [3:0]       freq_nxt;
    logic [1:0]       field_nxt;
    logic             hold_nxt;

    assign press = key_flag & ~key_state;
    assign rel   = key_flag[1:0] & key_state[1:0];

    // Step is combinational so a press in cycle N is visible in cycle N+1.
    // A release suppresses a terminal-count step in the same cycle.
    always_comb begin
        step = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (press[i]) begin
                step[i] = 1'b1;
            end else if (!rel[i]) begin
                case (key_st[i])
                    PRESSED: step[i] = (key_cnt[i] == LONG_LAST);
                    REPEAT:  step[i] = (key_cnt[i] == REPEAT_LAST);
                    default: step[i] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                key_st[i]  <= IDLE;
                key_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (press[i]) begin
                    // also covers a press with a lost release: restart timing
                    key_st[i]  <= PRESSED;
                    key_cnt[i] <= '0;
                end else if (rel[i]) begin
                    key_st[i]  <= IDLE;
                    key_cnt[i] <= '0;
                end else begin
                    case (key_st[i])
                        PRESSED: begin
                            if (key_cnt[i] == LONG_LAST) begin
                                key_st[i]  <= REPEAT;
                                key_cnt[i] <= '0;
                            end else begin
                                key_cnt[i] <= key_cnt[i] + 1'b1;
                            end
                        end
                        REPEAT: begin
                            if (key_cnt[i] == REPEAT_LAST) begin
                                key_cnt[i] <= '0;
                            end else begin
                                key_cnt[i] <= key_cnt[i] + 1'b1;
                            end
                        end
                        default: begin
                            key_st[i]  <= IDLE;
                            key_cnt[i] <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // Simultaneous UP and DOWN steps cancel.
    assign up = step[0] & ~step[1];
    assign dn = step[1] & ~step[0];

    always_comb begin
        wave_nxt  = wave_sel;
        amp_nxt   = amp_idx;
        freq_nxt  = freq_idx;
        field_nxt = (field_sel == 2'd3) ? 2'd0 : field_sel;
        hold_nxt  = hold;
        if (press[3]) begin
            hold_nxt = ~hold;
        end else if (!hold) begin
            if (press[2]) begin
                field_nxt = (field_sel >= 2'd2) ? 2'd0 : field_sel + 2'd1;
            end else if (up || dn) begin
                case (field_sel)
                    2'd0: wave_nxt = up ? wave_sel + 2'd1 : wave_sel - 2'd1;
                    2'd1: begin
                        if (up && amp_idx != 3'd7) begin
                            amp_nxt = amp_idx + 3'd1;
                        end else if (dn && amp_idx != 3'd0) begin
                            amp_nxt = amp_idx - 3'd1;
                        end
                    end
                    2'd2: begin
                        if (up && freq_idx < FREQ_MAX_V) begin
                            freq_nxt = freq_idx + 4'd1;
                        end else if (dn && freq_idx != 4'd0) begin
                            freq_nxt = freq_idx - 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wave_sel   <= 2'd0;
            amp_idx    <= AMP_RST_V;
            freq_idx   <= 4'd0;
            field_sel  <= 2'd0;
            hold       <= 1'b0;
            cfg_update <= 1'b0;
        end else begin
            wave_sel   <= wave_nxt;
            amp_idx    <= amp_nxt;
            freq_idx   <= freq_nxt;
            field_sel  <= field_nxt;
            hold       <= hold_nxt;
            cfg_update <= {wave_nxt, amp_nxt, freq_nxt, field_nxt, hold_nxt}
                       != {wave_sel, amp_idx, freq_idx, field_sel, hold};
        end
    end

endmodule

// File: tb/tb_wave_key_ctrl.sv
// Bench for wave_key_ctrl with short timing (LONG_CYC=20, REPEAT_CYC=5).
// Expected outputs are queued when stimulus is driven and compared one
// cycle later, just after the edge that consumes that stimulus.

module tb_wave_key_ctrl;

    localparam int LONG_CYC   = 20;
    localparam int REPEAT_CYC = 5;

    typedef struct packed {
        logic [1:0] wave;
        logic [2:0] amp;
        logic [3:0] freq;
        logic [1:0] field;
        logic       hold;
        logic       upd;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key_flag = 4'h0;
    logic [3:0] key_state = 4'hF;
    logic [1:0] wave_sel;
    logic [2:0] amp_idx;
    logic [3:0] freq_idx;
    logic [1:0] field_sel;
    logic       hold;
    logic       cfg_update;

    int    total = 0;
    int    bad = 0;
    exp_t  sb_q[$];
    string nm_q[$];
    exp_t  cur;
    logic [3:0] held = 4'hF;
    logic  done = 1'b0;
    logic  done_seen = 1'b0;
    vec_t  tbl [19];

    always #5 clk = ~clk;

    wave_key_ctrl #(
        .LONG_CYC   (LONG_CYC),
        .REPEAT_CYC (REPEAT_CYC),
        .CNT_W      (25),
        .AMP_RST    (4),
        .FREQ_MAX   (9)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_flag   (key_flag),
        .key_state  (key_state),
        .wave_sel   (wave_sel),
        .amp_idx    (amp_idx),
        .freq_idx   (freq_idx),
        .field_sel  (field_sel),
        .hold       (hold),
        .cfg_update (cfg_update)
    );

    always @(posedge clk) begin
        #1;
        begin
            exp_t  e;
            string nm;
            exp_t  got;
            got = {wave_sel, amp_idx, freq_idx, field_sel, hold, cfg_update};
            if (sb_q.size() > 0) begin
                e  = sb_q.pop_front();
                nm = nm_q.pop_front();
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL %s: got w=%0d a=%0d f=%0d fs=%0d h=%0d u=%0d, want w=%0d a=%0d f=%0d fs=%0d h=%0d u=%0d",
                             nm, wave_sel, amp_idx, freq_idx, field_sel, hold, cfg_update,
                             e.wave, e.amp, e.freq, e.field, e.hold, e.upd);
                end
            end else if (done && !done_seen) begin
                done_seen = 1'b1;
                total++;
                if (nm_q.size() != 0) begin
                    bad++;
                    $display("FAIL drain: got %0d pending, want 0", nm_q.size());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want test end");
        $fatal(1, "timeout");
    end

    function automatic exp_t mk(input int w, input int a, input int f,
                                input int fs, input int h, input int u);
        exp_t e;
        e.wave  = 2'(w);
        e.amp   = 3'(a);
        e.freq  = 4'(f);
        e.field = 2'(fs);
        e.hold  = 1'(h);
        e.upd   = 1'(u);
        return e;
    endfunction

    task automatic tick(input logic r, input logic [3:0] f, input logic chk, input string nm);
        @(posedge clk);
        #2;
        reset     = r;
        key_flag  = f;
        key_state = held;
        if (chk) begin
            sb_q.push_back(cur);
            nm_q.push_back(nm);
        end
    endtask

    task automatic press(input logic [3:0] m, input string nm);
        held = held & ~m;
        tick(1'b0, m, 1'b1, nm);
    endtask

    task automatic release_k(input logic [3:0] m, input string nm);
        held = held | m;
        tick(1'b0, m, 1'b1, nm);
    endtask

    task automatic idle(input string nm);
        tick(1'b0, 4'h0, 1'b1, nm);
    endtask

    task automatic tap(input logic [3:0] m, input exp_t e, input string nm);
        cur = e;
        press(m, nm);
        cur.upd = 1'b0;
        release_k(m, nm);
    endtask

    initial begin
        logic [3:0] nf;
        tbl[0]  = '{4'h4, mk(0,4,0,1,0,1)};
        tbl[1]  = '{4'h1, mk(0,5,0,1,0,1)};
        tbl[2]  = '{4'h2, mk(0,4,0,1,0,1)};
        tbl[3]  = '{4'h3, mk(0,4,0,1,0,0)};
        tbl[4]  = '{4'h5, mk(0,4,0,2,0,1)};
        tbl[5]  = '{4'h2, mk(0,4,0,2,0,0)};
        tbl[6]  = '{4'h1, mk(0,4,1,2,0,1)};
        tbl[7]  = '{4'h8, mk(0,4,1,2,1,1)};
        tbl[8]  = '{4'h1, mk(0,4,1,2,1,0)};
        tbl[9]  = '{4'h4, mk(0,4,1,2,1,0)};
        tbl[10] = '{4'hC, mk(0,4,1,2,0,1)};
        tbl[11] = '{4'h9, mk(0,4,1,2,1,1)};
        tbl[12] = '{4'h8, mk(0,4,1,2,0,1)};
        tbl[13] = '{4'h4, mk(0,4,1,0,0,1)};
        tbl[14] = '{4'h2, mk(3,4,1,0,0,1)};
        tbl[15] = '{4'h1, mk(0,4,1,0,0,1)};
        tbl[16] = '{4'h1, mk(1,4,1,0,0,1)};
        tbl[17] = '{4'h4, mk(1,4,1,1,0,1)};
        tbl[18] = '{4'h4, mk(1,4,1,2,0,1)};

        // reset values
        cur = mk(0,4,0,0,0,0);
        tick(1'b1, 4'h0, 1'b1, "reset");
        tick(1'b1, 4'h0, 1'b1, "reset");

        // reset in the middle of a held key aborts it
        cur = mk(1,4,0,0,0,1);
        press(4'h1, "pre_reset_up");
        cur.upd = 1'b0;
        repeat (5) idle("pre_reset_held");
        cur = mk(0,4,0,0,0,0);
        repeat (3) tick(1'b1, 4'h0, 1'b1, "mid_reset");
        repeat (30) idle("post_reset_held");
        release_k(4'h1, "post_reset_release");

        // single-tap table
        for (int i = 0; i < 19; i++) begin
            tap(tbl[i].mask, tbl[i].e, $sformatf("tbl%0d", i));
        end

        // freq saturation: state is w1 a4 f1 fs2 h0
        cur = mk(1,4,1,2,0,0);
        for (int i = 0; i < 12; i++) begin
            exp_t e;
            e = cur;
            nf = (cur.freq < 4'd9) ? cur.freq + 4'd1 : 4'd9;
            e.upd  = (nf != cur.freq);
            e.freq = nf;
            tap(4'h1, e, "freq_up");
        end

        // to amp field (2 -> 0 -> 1)
        tap(4'h4, mk(1,4,9,0,0,1), "mode_to0");
        tap(4'h4, mk(1,4,9,1,0,1), "mode_to1");

        // long press with auto-repeat on amp
        cur = mk(1,5,9,1,0,1);
        press(4'h1, "amp_press");
        for (int k = 1; k <= 40; k++) begin
            cur.amp = (k >= 25) ? 3'd7 : (k >= 20) ? 3'd6 : 3'd5;
            cur.upd = (k == 20 || k == 25);
            if (k < 40) idle("amp_hold");
            else release_k(4'h1, "amp_release");
        end

        // to wave field (1 -> 2 -> 0)
        tap(4'h4, mk(1,7,9,2,0,1), "mode_to2");
        tap(4'h4, mk(1,7,9,0,0,1), "mode_to0b");

        // release in the cycle the long-press step would fire wins
        cur = mk(2,7,9,0,0,1);
        press(4'h1, "wave_press");
        cur.upd = 1'b0;
        for (int k = 1; k < LONG_CYC; k++) idle("wave_hold");
        release_k(4'h1, "release_vs_step");
        repeat (30) idle("no_repeat_after_release");

        // press with a lost release restarts timing and steps
        cur = mk(1,7,9,0,0,1);
        press(4'h2, "down_press");
        cur.upd = 1'b0;
        repeat (5) idle("down_hold");
        cur = mk(0,7,9,0,0,1);
        press(4'h2, "down_repress");
        cur.upd = 1'b0;
        for (int j = 1; j <= LONG_CYC; j++) begin
            if (j == LONG_CYC) begin
                cur.wave = 2'd3;
                cur.upd  = 1'b1;
            end
            idle("down_restart_hold");
        end
        cur.upd = 1'b0;
        release_k(4'h2, "down_release");

        tick(1'b0, 4'h0, 1'b0, "");
        repeat (2) @(posedge clk);
        done = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_key_ctrl.md
Name: wave_key_ctrl

Overview:
- Consumes the debounced outputs of four key filters and drives the waveform-generator configuration for the HDMI wave display.
- Key roles: UP (key0), DOWN (key1), MODE (key2), HOLD (key3).
- UP/DOWN support short press, long press and auto-repeat. MODE selects which field UP/DOWN adjust. HOLD toggles freeze.
- Outputs are registered and feed the wave generator and the on-screen status overlay.

Parameters:
- LONG_CYC, 25_000_000, cycles a key must stay held after its first step before auto-repeat starts (0.5 s at 50 MHz).
- REPEAT_CYC, 5_000_000, cycles between auto-repeat steps (100 ms).
- CNT_W, 25, width of each per-key hold counter; must be able to hold max(LONG_CYC, REPEAT_CYC)-1.
- AMP_RST, 4, reset value of amp_idx (0..7).
- FREQ_MAX, 9, upper saturation limit of freq_idx (at most 15).

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- key_flag  in  4  one-cycle debounced event pulse per key, bit i = key i
- key_state  in  4  debounced level per key: 0 = pressed, 1 = released
- wave_sel  out  2  waveform: 0 sine, 1 square, 2 triangle, 3 sawtooth
- amp_idx  out  3  amplitude index
- freq_idx  out  4  frequency index
- field_sel  out  2  field adjusted by UP/DOWN: 0 wave, 1 amp, 2 freq
- hold  out  1  display freeze
- cfg_update  out  1  one-cycle pulse, high in the first cycle a changed value is visible

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on the rising edge of clk.
  - Synchronous, active-high reset. Reset values: wave_sel=0, amp_idx=AMP_RST, freq_idx=0, field_sel=0, hold=0, cfg_update=0. All per-key FSMs go to IDLE and all counters to 0.
  - Reset asserted mid-hold or mid-repeat aborts the operation. After reset deasserts, no step is generated until a new press event arrives.
- Event decode for key i:
  - press_i = key_flag[i] & ~key_state[i]
  - release_i = key_flag[i] & key_state[i]
- UP/DOWN per-key FSM (independent instance for key0 and key1), states IDLE, PRESSED, REPEAT:
  - IDLE: on press, emit step, go to PRESSED with cnt=0.
  - PRESSED: cnt increments each cycle. When cnt==LONG_CYC-1, emit step, go to REPEAT, cnt=0.
  - REPEAT: cnt increments each cycle. When cnt==REPEAT_CYC-1, emit step, cnt=0.
  - PRESSED or REPEAT: release returns to IDLE with cnt=0. Release takes priority over a step in the same cycle.
  - A press seen in PRESSED or REPEAT (lost release) restarts PRESSED with cnt=0 and emits a step.
- MODE and HOLD: act on press only; releases are ignored; no repeat.
- Step timing:
  - A press flag in cycle N makes the new value visible in cycle N+1.
  - While the key stays held, the first repeat is visible at N+1+LONG_CYC, then one every REPEAT_CYC cycles.
- Arbitration, per cycle, in priority order:
  1. HOLD press: toggle hold. UP, DOWN and MODE in the same cycle are dropped.
  2. MODE press (only when hold=0): field_sel advances 0→1→2→0. UP/DOWN steps in the same cycle are dropped.
  3. UP step and DOWN step together: cancel, no change.
  4. A single UP or DOWN step (only when hold=0) is applied to the selected field.
  - When hold=1, UP/DOWN steps and MODE presses are ignored. The FSMs keep running.
- Field arithmetic:
  - wave_sel: UP +1 mod 4, DOWN -1 mod 4 (wraps 3↔0).
  - amp_idx: saturates at 0 and 7.
  - freq_idx: saturates at 0 and FREQ_MAX.
  - field_sel value 3 is unreachable; if it is ever seen, it is forced to 0 on the next cycle.
- cfg_update:
  - Asserted for exactly one cycle whenever wave_sel, amp_idx, freq_idx, field_sel or hold changed on that edge.
  - A saturated step that changes nothing produces no pulse.

Test Plan (LONG_CYC=20, REPEAT_CYC=5):
- Reset, then hold reset for 3 cycles mid-operation → outputs 0/4/0/0/0, cfg_update=0. No step after deassert while key0 is still held without a new flag.
- field_sel=1. Press key0 at cycle N, hold for 40 cycles, release → amp_idx goes 4→5 at N+1, 6 at N+21, 7 at N+26, then stays 7. cfg_update pulses exactly 3 times.
- field_sel=0 (MODE pressed 3 times from reset). Press key1 once → wave_sel 0→3 (wrap), cfg_update pulses once per change.
- Press key3 → hold=1. Then press key0 and key2 → no output change. Press key3 again → hold=0, cfg_update pulses once per toggle.
- Same-cycle key0+key1 presses → no change, no cfg_update. Same-cycle key2+key0 presses → field_sel advances, value field unchanged.
- field_sel=2, freq_idx=0. Press key1 → stays 0, no cfg_update. 12 UP steps → stops at 9.
